// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM state encoding and bus-level bit constants.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_RX_BYTE,
        ST_RX_ACK,
        ST_TX_BYTE,
        ST_TX_ACK,
        ST_WAIT_STOP
    } i2c_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA front end: 2-FF synchronizer, FILTER_LEN-sample glitch filter, SCL edge
// strobes and START/STOP detection. Shared by the I2C master and target.
module i2c_bus_sync #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda,
    output logic sda_level,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [1:0]            scl_sync, sda_sync;
    logic [FILTER_LEN-2:0] scl_hist, sda_hist;
    logic [FILTER_LEN-1:0] scl_win, sda_win;
    logic                  scl_level, scl_prev, sda_prev;

    // The newest synchronized sample completes the window, keeping latency at 2+FILTER_LEN.
    assign scl_win = {scl_hist, scl_sync[1]};
    assign sda_win = {sda_hist, sda_sync[1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync  <= '1;
            sda_sync  <= '1;
            scl_hist  <= '1;
            sda_hist  <= '1;
            scl_level <= 1'b1;
            sda_level <= 1'b1;
            scl_prev  <= 1'b1;
            sda_prev  <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
            scl_hist <= scl_win[FILTER_LEN-2:0];
            sda_hist <= sda_win[FILTER_LEN-2:0];
            if (&scl_win)       scl_level <= 1'b1;
            else if (~|scl_win) scl_level <= 1'b0;
            if (&sda_win)       sda_level <= 1'b1;
            else if (~|sda_win) sda_level <= 1'b0;
            scl_prev <= scl_level;
            sda_prev <= sda_level;
        end
    end

    assign scl_rise = scl_level & ~scl_prev;
    assign scl_fall = ~scl_level & scl_prev;
    assign start    = ~sda_level & sda_prev & scl_level;
    assign stop     = sda_level & ~sda_prev & scl_level;

endmodule

// File: rtl/i2c_slave_controller.sv
// I2C target endpoint: 7-bit address match, RX/TX FIFO byte transfer, open-drain
// ACK/data on SDA. Never stretches SCL.
module i2c_slave_controller
    import i2c_pkg::*;
#(
    parameter int          FILTER_LEN = 3,
    parameter logic [7:0]  IDLE_FILL  = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] own_addr,
    output logic       read,
    input  logic [7:0] data_in,
    input  logic       empty_tx,
    output logic       write,
    output logic [7:0] data_out,
    input  logic       full_rx,
    output logic       busy,
    input  logic       scl,
    inout  wire        sda
);

    i2c_state_t state, state_next;

    logic       sda_level, scl_rise, scl_fall, start, stop;
    logic [3:0] bit_cnt;
    logic [7:0] shreg, tx_byte, rx_byte;
    logic       sda_oe, ack_phase, rw, rx_ack_bit, fetch_p, fetch_empty;
    logic       cnt_clr, cnt_inc, shift_in, sda_we, sda_d, phase_we, phase_d;
    logic       busy_set, busy_clr, addr_hit, rx_done, fetch, tx_shift;

    i2c_bus_sync #(.FILTER_LEN(FILTER_LEN)) u_sync (
        .clk       (clk),
        .reset     (reset),
        .scl       (scl),
        .sda       (sda),
        .sda_level (sda_level),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start     (start),
        .stop      (stop)
    );

    assign sda     = sda_oe ? 1'b0 : 1'bz;
    assign rx_byte = {shreg[6:0], sda_level};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        shift_in   = 1'b0;
        sda_we     = 1'b0;
        sda_d      = 1'b0;
        phase_we   = 1'b0;
        phase_d    = 1'b0;
        busy_set   = 1'b0;
        busy_clr   = 1'b0;
        addr_hit   = 1'b0;
        rx_done    = 1'b0;
        fetch      = 1'b0;
        tx_shift   = 1'b0;
        case (state)
            ST_ADDR: if (scl_rise) begin
                shift_in = 1'b1;
                cnt_inc  = 1'b1;
                if (bit_cnt == 4'd7) begin
                    if (shreg[6:0] == own_addr) begin
                        state_next = ST_ADDR_ACK;
                        addr_hit   = 1'b1;
                        busy_set   = 1'b1;
                    end else begin
                        state_next = ST_WAIT_STOP;
                        busy_clr   = 1'b1;
                    end
                end
            end
            // ack_phase marks that the ACK bit is on the bus; the next fall ends it.
            ST_ADDR_ACK: if (scl_fall) begin
                phase_we = 1'b1;
                phase_d  = ~ack_phase;
                if (!ack_phase) begin
                    sda_we = 1'b1;
                    sda_d  = 1'b1;
                    fetch  = (rw == RW_READ);
                end else begin
                    cnt_clr = 1'b1;
                    if (rw == RW_WRITE) begin
                        sda_we     = 1'b1;
                        state_next = ST_RX_BYTE;
                    end else begin
                        tx_shift   = 1'b1;
                        state_next = ST_TX_BYTE;
                    end
                end
            end
            ST_RX_BYTE: if (scl_rise) begin
                shift_in = 1'b1;
                cnt_inc  = 1'b1;
                if (bit_cnt == 4'd7) begin
                    rx_done    = 1'b1;
                    state_next = ST_RX_ACK;
                end
            end
            ST_RX_ACK: if (scl_fall) begin
                phase_we = 1'b1;
                phase_d  = ~ack_phase;
                sda_we   = 1'b1;
                if (!ack_phase) begin
                    sda_d = (rx_ack_bit == I2C_ACK);
                end else begin
                    cnt_clr    = 1'b1;
                    state_next = ST_RX_BYTE;
                end
            end
            ST_TX_BYTE: begin
                if (scl_rise) begin
                    cnt_inc = 1'b1;
                end else if (scl_fall) begin
                    if (bit_cnt == 4'd8) begin
                        sda_we     = 1'b1;
                        cnt_clr    = 1'b1;
                        state_next = ST_TX_ACK;
                    end else begin
                        tx_shift = 1'b1;
                    end
                end
            end
            ST_TX_ACK: begin
                if (scl_rise && !ack_phase) begin
                    if (sda_level == I2C_ACK) begin
                        fetch    = 1'b1;
                        phase_we = 1'b1;
                        phase_d  = 1'b1;
                    end else begin
                        state_next = ST_WAIT_STOP;
                    end
                end else if (scl_fall && ack_phase) begin
                    phase_we   = 1'b1;
                    tx_shift   = 1'b1;
                    state_next = ST_TX_BYTE;
                end
            end
            default: ;
        endcase
        if (tx_shift) begin
            sda_we = 1'b1;
            sda_d  = ~tx_byte[7];
        end
        // START/STOP preempt everything and discard any partial byte.
        if (start || stop) begin
            state_next = stop ? ST_IDLE : ST_ADDR;
            cnt_clr    = 1'b1;
            cnt_inc    = 1'b0;
            shift_in   = 1'b0;
            sda_we     = 1'b1;
            sda_d      = 1'b0;
            phase_we   = 1'b1;
            phase_d    = 1'b0;
            addr_hit   = 1'b0;
            rx_done    = 1'b0;
            fetch      = 1'b0;
            tx_shift   = 1'b0;
            busy_set   = 1'b0;
            busy_clr   = busy_clr | stop;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt     <= '0;
            sda_oe      <= 1'b0;
            ack_phase   <= 1'b0;
            busy        <= 1'b0;
            rw          <= RW_WRITE;
            rx_ack_bit  <= I2C_NACK;
            read        <= 1'b0;
            write       <= 1'b0;
            data_out    <= 8'h00;
            fetch_p     <= 1'b0;
            fetch_empty <= 1'b0;
        end else begin
            if (cnt_clr)      bit_cnt <= '0;
            else if (cnt_inc) bit_cnt <= bit_cnt + 4'd1;
            if (sda_we)   sda_oe    <= sda_d;
            if (phase_we) ack_phase <= phase_d;
            if (busy_set)      busy <= 1'b1;
            else if (busy_clr) busy <= 1'b0;
            if (addr_hit) rw <= sda_level;
            read    <= fetch & ~empty_tx;
            fetch_p <= fetch;
            if (fetch) fetch_empty <= empty_tx;
            write <= rx_done & ~full_rx;
            if (rx_done) begin
                rx_ack_bit <= full_rx ? I2C_NACK : I2C_ACK;
                if (!full_rx) data_out <= rx_byte;
            end
        end
    end

    // TX byte is captured the clk after the pop, when data_in is valid.
    always_ff @(posedge clk) begin
        if (shift_in) shreg <= rx_byte;
        if (fetch_p)       tx_byte <= fetch_empty ? IDLE_FILL : data_in;
        else if (tx_shift) tx_byte <= {tx_byte[6:0], 1'b1};
    end

endmodule
